// File: rtl/ccu_snoop_collect_pkg.sv
// Shared types for the snoop fan-out/fan-in stage: CRRESP field layout and
// AC/CR field widths.
package ccu_snoop_collect_pkg;

  localparam int unsigned CRRESP_W = 5;
  localparam int unsigned SNOOP_W  = 4;
  localparam int unsigned PROT_W   = 3;

  // Field order matches the CRRESP bus: bit 4 down to bit 0
  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } crresp_t;

  function automatic crresp_t crresp_merge(input crresp_t a, input crresp_t b);
    return crresp_t'(a | b);
  endfunction

endpackage

// File: rtl/ccu_snoop_collect_lzc.sv
// Lowest-index set-bit finder used to pick the master whose CD is forwarded.
module ccu_snoop_collect_lzc #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [IDX_W-1:0] cnt_o,
  output logic             empty_o
);

  // Scan from the top so the last hit, the lowest index, wins
  always_comb begin
    cnt_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in_i[i]) begin
        cnt_o = IDX_W'(i);
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/ccu_snoop_collect.sv
// Snoop fan-out/fan-in: broadcasts one AC to the masked masters, merges their
// CRs into a single response, forwards CD from one master and drains the rest.
module ccu_snoop_collect
  import ccu_snoop_collect_pkg::*;
#(
  parameter int unsigned NUM_MST    = 4,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          ac_valid_i,
  output logic                          ac_ready_o,
  input  logic [ADDR_WIDTH-1:0]         ac_addr_i,
  input  logic [SNOOP_W-1:0]            ac_snoop_i,
  input  logic [PROT_W-1:0]             ac_prot_i,
  input  logic [NUM_MST-1:0]            domain_mask_i,
  output logic                          cr_valid_o,
  input  logic                          cr_ready_i,
  output logic [CRRESP_W-1:0]           cr_resp_o,
  output logic                          cd_valid_o,
  input  logic                          cd_ready_i,
  output logic [DATA_WIDTH-1:0]         cd_data_o,
  output logic                          cd_last_o,
  output logic [NUM_MST-1:0]            snp_ac_valid_o,
  input  logic [NUM_MST-1:0]            snp_ac_ready_i,
  output logic [ADDR_WIDTH-1:0]         snp_ac_addr_o,
  output logic [SNOOP_W-1:0]            snp_ac_snoop_o,
  output logic [PROT_W-1:0]             snp_ac_prot_o,
  input  logic [NUM_MST-1:0]            snp_cr_valid_i,
  output logic [NUM_MST-1:0]            snp_cr_ready_o,
  input  logic [CRRESP_W*NUM_MST-1:0]   snp_cr_resp_i,
  input  logic [NUM_MST-1:0]            snp_cd_valid_i,
  output logic [NUM_MST-1:0]            snp_cd_ready_o,
  input  logic [DATA_WIDTH*NUM_MST-1:0] snp_cd_data_i,
  input  logic [NUM_MST-1:0]            snp_cd_last_i
);

  localparam int unsigned SEL_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  typedef enum logic [1:0] {S_IDLE, S_AC, S_RESP, S_CD} state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [SNOOP_W-1:0]    r_snoop;
  logic [PROT_W-1:0]     r_prot;
  logic [NUM_MST-1:0]    r_mask;
  logic [NUM_MST-1:0]    r_ac_done;
  logic [NUM_MST-1:0]    r_cr_done;
  logic [NUM_MST-1:0]    r_dt;
  logic [NUM_MST-1:0]    r_cd_done;
  crresp_t               r_resp;

  logic [NUM_MST-1:0]    w_ac_hs;
  logic [NUM_MST-1:0]    w_cr_hs;
  logic [NUM_MST-1:0]    w_cr_dt;
  logic [NUM_MST-1:0]    w_cd_hs;
  logic [NUM_MST-1:0]    w_cd_last_hs;
  crresp_t               w_cr_resp [NUM_MST];
  logic [DATA_WIDTH-1:0] w_cd_data [NUM_MST];
  crresp_t               w_cr_merge;
  logic [SEL_W-1:0]      w_sel;
  logic                  w_dt_empty;
  logic                  w_ac_hs_up;
  logic                  w_cr_hs_up;
  logic                  w_in_ac;
  logic                  w_in_cd;

  assign w_in_ac = (r_state == S_AC);
  assign w_in_cd = (r_state == S_CD);

  ccu_snoop_collect_lzc #(
    .WIDTH (NUM_MST),
    .IDX_W (SEL_W)
  ) u_sel_lzc (
    .in_i    (r_dt),
    .cnt_o   (w_sel),
    .empty_o (w_dt_empty)
  );

  for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_mst
    assign w_cd_data[gi] = snp_cd_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    assign w_cr_resp[gi] = crresp_t'(snp_cr_resp_i[gi*CRRESP_W +: CRRESP_W]);

    assign snp_ac_valid_o[gi] = w_in_ac & r_mask[gi] & ~r_ac_done[gi];
    assign w_ac_hs[gi]        = snp_ac_valid_o[gi] & snp_ac_ready_i[gi];

    // A master's CR is only taken once its AC handshake is on record
    assign snp_cr_ready_o[gi] = w_in_ac & r_mask[gi] & r_ac_done[gi] & ~r_cr_done[gi];
    assign w_cr_hs[gi]        = snp_cr_ready_o[gi] & snp_cr_valid_i[gi];
    assign w_cr_dt[gi]        = w_cr_hs[gi] & w_cr_resp[gi].data_transfer;

    // Selected master follows upstream backpressure; others drain freely
    assign snp_cd_ready_o[gi] = w_in_cd & r_dt[gi] & ~r_cd_done[gi] &
                                ((w_sel == SEL_W'(gi)) ? cd_ready_i : 1'b1);
    assign w_cd_hs[gi]        = snp_cd_valid_i[gi] & snp_cd_ready_o[gi];
    assign w_cd_last_hs[gi]   = w_cd_hs[gi] & snp_cd_last_i[gi];
  end

  always_comb begin
    w_cr_merge = r_resp;
    for (int i = 0; i < NUM_MST; i++) begin
      if (w_cr_hs[i]) begin
        w_cr_merge = crresp_merge(w_cr_merge, w_cr_resp[i]);
      end
    end
  end

  assign ac_ready_o = (r_state == S_IDLE);
  assign w_ac_hs_up = ac_valid_i & ac_ready_o;

  assign cr_valid_o = (r_state == S_RESP);
  assign cr_resp_o  = r_resp;
  assign w_cr_hs_up = cr_valid_o & cr_ready_i;

  assign cd_valid_o = w_in_cd & ~r_cd_done[w_sel] & snp_cd_valid_i[w_sel];
  assign cd_data_o  = w_cd_data[w_sel];
  assign cd_last_o  = snp_cd_last_i[w_sel];

  assign snp_ac_addr_o  = r_addr;
  assign snp_ac_snoop_o = r_snoop;
  assign snp_ac_prot_o  = r_prot;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_ac_hs_up) begin
          w_state_next = (|domain_mask_i) ? S_AC : S_RESP;
        end
      end
      S_AC: begin
        if ((r_cr_done | w_cr_hs) == r_mask) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (w_cr_hs_up) begin
          w_state_next = w_dt_empty ? S_IDLE : S_CD;
        end
      end
      S_CD: begin
        if ((r_cd_done | w_cd_last_hs) == r_dt) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr    <= '0;
      r_snoop   <= '0;
      r_prot    <= '0;
      r_mask    <= '0;
      r_ac_done <= '0;
      r_cr_done <= '0;
      r_dt      <= '0;
      r_cd_done <= '0;
      r_resp    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ac_hs_up) begin
            r_addr    <= ac_addr_i;
            r_snoop   <= ac_snoop_i;
            r_prot    <= ac_prot_i;
            r_mask    <= domain_mask_i;
            r_ac_done <= '0;
            r_cr_done <= '0;
            r_dt      <= '0;
            r_cd_done <= '0;
            r_resp    <= '0;
          end
        end
        S_AC: begin
          r_ac_done <= r_ac_done | w_ac_hs;
          r_cr_done <= r_cr_done | w_cr_hs;
          r_dt      <= r_dt | w_cr_dt;
          r_resp    <= w_cr_merge;
        end
        S_CD: begin
          r_cd_done <= r_cd_done | w_cd_last_hs;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ccu_snoop_collect.sv
// Scoreboard bench for ccu_snoop_collect: directed snoops, a behavioural
// master model, and a negedge monitor that checks every CR/CD handshake.
module tb_ccu_snoop_collect;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 64;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            ac_valid_i;
  logic            ac_ready_o;
  logic [AW-1:0]   ac_addr_i;
  logic [3:0]      ac_snoop_i;
  logic [2:0]      ac_prot_i;
  logic [N-1:0]    domain_mask_i;
  logic            cr_valid_o;
  logic            cr_ready_i;
  logic [4:0]      cr_resp_o;
  logic            cd_valid_o;
  logic            cd_ready_i;
  logic [DW-1:0]   cd_data_o;
  logic            cd_last_o;
  logic [N-1:0]    snp_ac_valid_o;
  logic [N-1:0]    snp_ac_ready_i;
  logic [AW-1:0]   snp_ac_addr_o;
  logic [3:0]      snp_ac_snoop_o;
  logic [2:0]      snp_ac_prot_o;
  logic [N-1:0]    snp_cr_valid_i;
  logic [N-1:0]    snp_cr_ready_o;
  logic [5*N-1:0]  snp_cr_resp_i;
  logic [N-1:0]    snp_cd_valid_i;
  logic [N-1:0]    snp_cd_ready_o;
  logic [DW*N-1:0] snp_cd_data_i;
  logic [N-1:0]    snp_cd_last_i;

  always #5 clk_i = ~clk_i;

  ccu_snoop_collect #(.NUM_MST(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
    .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i), .domain_mask_i(domain_mask_i),
    .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
    .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o),
    .cd_last_o(cd_last_o),
    .snp_ac_valid_o(snp_ac_valid_o), .snp_ac_ready_i(snp_ac_ready_i),
    .snp_ac_addr_o(snp_ac_addr_o), .snp_ac_snoop_o(snp_ac_snoop_o),
    .snp_ac_prot_o(snp_ac_prot_o),
    .snp_cr_valid_i(snp_cr_valid_i), .snp_cr_ready_o(snp_cr_ready_o),
    .snp_cr_resp_i(snp_cr_resp_i),
    .snp_cd_valid_i(snp_cd_valid_i), .snp_cd_ready_o(snp_cd_ready_o),
    .snp_cd_data_i(snp_cd_data_i), .snp_cd_last_i(snp_cd_last_i)
  );

  int total = 0;
  int bad   = 0;

  logic [4:0]    cr_q [$];
  logic [DW:0]   cd_q [$];   // {last, data}
  logic [N-1:0]  cur_mask = '0;
  logic [N-1:0]  cur_dt   = '0;
  logic [AW-1:0] cur_addr = '0;
  logic [3:0]    cur_snoop = '0;
  int            fwd_beats = 0;

  int            cfg_ac_wait [N];
  int            cfg_cr_wait [N];
  int            cfg_beats   [N];
  logic [4:0]    cfg_resp    [N];
  logic [DW-1:0] cfg_base    [N];
  int            ms     [N];
  int            cnt    [N];
  int            beat   [N];
  int            cd_tot [N];

  task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_beat(input int i);
    snp_cd_valid_i[i] = 1'b1;
    snp_cd_data_i[i*DW +: DW] = cfg_base[i] + DW'(beat[i]);
    snp_cd_last_i[i] = (beat[i] == cfg_beats[i] - 1);
  endtask

  // Behavioural masters: AC accept after a delay, CR after a delay, then CD beats
  initial begin : master_model
    logic [N-1:0] ac_hs, cr_hs, cd_hs;
    logic rst_q;
    snp_ac_ready_i = '0; snp_cr_valid_i = '0; snp_cr_resp_i = '0;
    snp_cd_valid_i = '0; snp_cd_data_i = '0; snp_cd_last_i = '0;
    for (int i = 0; i < N; i++) begin
      ms[i] = 0; cnt[i] = 0; beat[i] = 0; cd_tot[i] = 0;
    end
    forever begin
      @(negedge clk_i);
      ac_hs = snp_ac_valid_o & snp_ac_ready_i;
      cr_hs = snp_cr_valid_i & snp_cr_ready_o;
      cd_hs = snp_cd_valid_i & snp_cd_ready_o;
      rst_q = rst_i;
      @(posedge clk_i); #1;
      for (int i = 0; i < N; i++) begin
        if (rst_q) begin
          ms[i] = 0; cnt[i] = 0; beat[i] = 0;
          snp_ac_ready_i[i] = 1'b0; snp_cr_valid_i[i] = 1'b0;
          snp_cd_valid_i[i] = 1'b0; snp_cd_last_i[i] = 1'b0;
        end else begin
          if (cd_hs[i]) cd_tot[i]++;
          case (ms[i])
            0: if (snp_ac_valid_o[i]) begin
                 if (cnt[i] >= cfg_ac_wait[i]) begin snp_ac_ready_i[i] = 1'b1; ms[i] = 1; end
                 else cnt[i]++;
               end
            1: if (ac_hs[i]) begin
                 snp_ac_ready_i[i] = 1'b0; cnt[i] = 0;
                 if (cfg_cr_wait[i] == 0) begin
                   snp_cr_valid_i[i] = 1'b1; snp_cr_resp_i[i*5 +: 5] = cfg_resp[i]; ms[i] = 3;
                 end else ms[i] = 2;
               end
            2: if (cnt[i] + 1 >= cfg_cr_wait[i]) begin
                 snp_cr_valid_i[i] = 1'b1; snp_cr_resp_i[i*5 +: 5] = cfg_resp[i]; ms[i] = 3;
               end else cnt[i]++;
            3: if (cr_hs[i]) begin
                 snp_cr_valid_i[i] = 1'b0;
                 if (cfg_beats[i] > 0) begin beat[i] = 0; drive_beat(i); ms[i] = 4; end
                 else ms[i] = 5;
               end
            4: if (cd_hs[i]) begin
                 beat[i]++;
                 if (beat[i] == cfg_beats[i]) begin
                   snp_cd_valid_i[i] = 1'b0; snp_cd_last_i[i] = 1'b0; ms[i] = 5;
                 end else drive_beat(i);
               end else if (ac_ready_o) begin
                 snp_cd_valid_i[i] = 1'b0; snp_cd_last_i[i] = 1'b0; ms[i] = 0; cnt[i] = 0;
               end
            default: if (ac_ready_o) begin ms[i] = 0; cnt[i] = 0; end
          endcase
        end
      end
    end
  end

  // Monitor: scoreboard pops plus per-cycle protocol checks
  initial begin : monitor
    logic          prev_stall = 1'b0;
    logic [DW:0]   prev_beat = '0;
    logic [DW:0]   exp;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        prev_stall = 1'b0;
      end else begin
        if (|snp_ac_valid_o) begin
          chk("ac_addr", snp_ac_addr_o, cur_addr);
          chk("ac_snoop", snp_ac_snoop_o, cur_snoop);
        end
        for (int i = 0; i < N; i++) begin
          if (snp_ac_valid_o[i]) chk($sformatf("ac_valid_in_mask_m%0d", i), cur_mask[i], 1);
          if (snp_cr_ready_o[i]) chk($sformatf("cr_ready_after_ac_m%0d", i), ms[i] >= 2, 1);
          if (snp_cd_ready_o[i]) chk($sformatf("cd_ready_dt_only_m%0d", i), cur_dt[i], 1);
        end
        if (cr_valid_o && cr_ready_i) begin
          $display("CR resp=%b", cr_resp_o);
          chk("cr_expected", cr_q.size() != 0, 1);
          if (cr_q.size() != 0) begin
            exp = DW'(cr_q.pop_front());
            chk("cr_resp", cr_resp_o, exp);
          end
        end
        if (prev_stall) begin
          chk("cd_hold_valid", cd_valid_o, 1);
          chk("cd_hold_beat", {cd_last_o, cd_data_o}, prev_beat);
        end
        if (cd_valid_o && cd_ready_i) begin
          $display("CD data=%h last=%b", cd_data_o, cd_last_o);
          fwd_beats++;
          chk("cd_expected", cd_q.size() != 0, 1);
          if (cd_q.size() != 0) begin
            exp = cd_q.pop_front();
            chk("cd_beat", {cd_last_o, cd_data_o}, exp);
          end
        end
        prev_stall = cd_valid_o && !cd_ready_i;
        prev_beat  = {cd_last_o, cd_data_o};
      end
    end
  end

  task automatic clear_cfg();
    for (int i = 0; i < N; i++) begin
      cfg_ac_wait[i] = 0; cfg_cr_wait[i] = 0; cfg_beats[i] = 0;
      cfg_resp[i] = '0; cfg_base[i] = '0;
    end
  endtask

  task automatic set_mst(input int i, input int acw, input int crw, input logic [4:0] resp,
                         input int beats, input logic [DW-1:0] base);
    cfg_ac_wait[i] = acw; cfg_cr_wait[i] = crw; cfg_resp[i] = resp;
    cfg_beats[i] = beats; cfg_base[i] = base;
  endtask

  task automatic push_beats(input logic [DW-1:0] base, input int beats);
    for (int k = 0; k < beats; k++) cd_q.push_back({(k == beats - 1), base + DW'(k)});
  endtask

  // Issue one AC upstream; returns at posedge+1 after the accepting edge
  task automatic issue(input logic [N-1:0] mask, input logic [AW-1:0] addr, input logic [3:0] snoop);
    bit ok = 0;
    cur_mask = mask; cur_addr = addr; cur_snoop = snoop;
    for (int i = 0; i < N; i++) cur_dt[i] = mask[i] & cfg_resp[i][0];
    @(posedge clk_i); #1;
    ac_valid_i = 1'b1; ac_addr_i = addr; ac_snoop_i = snoop; ac_prot_i = 3'b010;
    domain_mask_i = mask;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk_i);
      if (ac_ready_o) ok = 1;
      @(posedge clk_i); #1;
    end
    ac_valid_i = 1'b0; domain_mask_i = '0; ac_addr_i = '0;
    chk("ac_accepted", ok, 1);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk_i);
      if (ac_ready_o) ok = 1;
    end
    chk(name, ok, 1);
  endtask

  task automatic wait_fwd(input int target, input string name);
    bit ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(posedge clk_i); #1;
      if (fwd_beats >= target) ok = 1;
    end
    chk(name, ok, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  initial begin : main
    bit ok;
    int snap2, snap3, f0;
    ac_valid_i = 1'b0; ac_addr_i = '0; ac_snoop_i = '0; ac_prot_i = '0;
    domain_mask_i = '0; cr_ready_i = 1'b1; cd_ready_i = 1'b1;
    clear_cfg();
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ac_ready", ac_ready_o, 1);
    chk("rst_cr_valid", cr_valid_o, 0);
    chk("rst_cd_valid", cd_valid_o, 0);
    chk("rst_snp_ac_valid", snp_ac_valid_o, 0);
    chk("rst_snp_cd_ready", snp_cd_ready_o, 0);

    // 1: two masters, no data transfer
    clear_cfg();
    set_mst(0, 0, 0, 5'b00000, 0, '0);
    set_mst(2, 1, 0, 5'b00000, 0, '0);
    cr_q.push_back(5'b00000);
    issue(4'b0101, 64'h0000_1000_0000_0040, 4'h1);
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk_i);
      if (cr_valid_o && cr_ready_i) ok = 1;
    end
    chk("t1_cr_seen", ok, 1);
    @(negedge clk_i);
    chk("t1_ac_ready_next", ac_ready_o, 1);
    chk("t1_no_cd", cd_valid_o, 0);

    // 2: empty mask answers straight away
    clear_cfg();
    cr_q.push_back(5'b00000);
    issue(4'b0000, 64'h0000_0000_0000_0080, 4'h7);
    @(negedge clk_i);
    chk("t2_cr_valid_1cyc", cr_valid_o, 1);
    chk("t2_no_snp_ac", snp_ac_valid_o, 0);
    wait_idle("t2_idle");

    // 3: merge, forward m1, drain m2, m3 never readied
    clear_cfg();
    set_mst(1, 0, 0, 5'b00001, 4, 64'h1100);
    set_mst(2, 1, 1, 5'b01101, 4, 64'h2200);
    set_mst(3, 0, 2, 5'b10000, 2, 64'h3300);
    snap2 = cd_tot[2]; snap3 = cd_tot[3];
    cr_q.push_back(5'b11101);
    push_beats(64'h1100, 4);
    issue(4'b1110, 64'h0000_2000_0000_0100, 4'h9);
    wait_idle("t3_idle");
    chk("t3_m2_drained", cd_tot[2] - snap2, 4);
    chk("t3_m3_not_taken", cd_tot[3] - snap3, 0);
    chk("t3_cd_q_empty", cd_q.size(), 0);

    // 4: out-of-order AC readies, CR from m0 first
    clear_cfg();
    set_mst(3, 0, 4, 5'b01000, 0, '0);
    set_mst(0, 2, 0, 5'b00010, 0, '0);
    cr_q.push_back(5'b01010);
    issue(4'b1001, 64'h0000_3000_0000_0200, 4'h2);
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk_i);
      if (cr_valid_o) ok = 1;
    end
    chk("t4_cr_valid_seen", ok, 1);
    chk("t4_cr_after_both", {ms[0] == 5, ms[3] == 5}, 2'b11);
    wait_idle("t4_idle");

    // 5: upstream CD stall mid-burst
    clear_cfg();
    set_mst(0, 0, 0, 5'b00001, 4, 64'hA000);
    set_mst(1, 1, 0, 5'b00001, 4, 64'hB000);
    snap2 = cd_tot[1];
    f0 = fwd_beats;
    cr_q.push_back(5'b00001);
    push_beats(64'hA000, 4);
    issue(4'b0011, 64'h0000_4000_0000_0300, 4'h1);
    wait_fwd(f0 + 1, "t5_first_beat");
    cd_ready_i = 1'b0;
    repeat (3) begin @(posedge clk_i); #1; end
    cd_ready_i = 1'b1;
    @(negedge clk_i);
    chk("t5_drain_not_stalled", cd_tot[1] - snap2, 4);
    wait_idle("t5_idle");
    chk("t5_cd_q_empty", cd_q.size(), 0);

    // 6: reset during CD after two beats, then a clean snoop
    clear_cfg();
    set_mst(0, 0, 0, 5'b00001, 4, 64'hC000);
    set_mst(1, 0, 0, 5'b00001, 4, 64'hD000);
    f0 = fwd_beats;
    cr_q.push_back(5'b00001);
    push_beats(64'hC000, 4);
    issue(4'b0011, 64'h0000_5000_0000_0400, 4'h1);
    wait_fwd(f0 + 2, "t6_two_beats");
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    cr_q.delete();
    cd_q.delete();
    @(negedge clk_i);
    chk("t6_ac_ready", ac_ready_o, 1);
    chk("t6_cr_valid", cr_valid_o, 0);
    chk("t6_cd_valid", cd_valid_o, 0);
    chk("t6_snp_ac_valid", snp_ac_valid_o, 0);
    chk("t6_snp_cr_ready", snp_cr_ready_o, 0);
    chk("t6_snp_cd_ready", snp_cd_ready_o, 0);
    clear_cfg();
    set_mst(1, 0, 0, 5'b00001, 2, 64'hE000);
    cr_q.push_back(5'b00001);
    push_beats(64'hE000, 2);
    issue(4'b0010, 64'h0000_6000_0000_0500, 4'h3);
    wait_idle("t6_new_idle");
    chk("t6_cr_q_empty", cr_q.size(), 0);
    chk("t6_cd_q_empty", cd_q.size(), 0);

    repeat (3) @(posedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
